// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fft_pkg
// Description : Shared defaults, FSM state encoding and helper functions for
//               the FFT twiddle-factor fetch logic.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    // Default geometry: single-precision twiddle words, 4K-entry ROMs, 8-point FFT
    localparam int c_DEFAULT_DATA_WIDTH = 32;
    localparam int c_DEFAULT_ADDR_WIDTH = 12;
    localparam int c_DEFAULT_LOG2N      = 3;

    // Sequencer state encoding
    localparam int         c_ST_WIDTH = 2;
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    // Width needed to hold a stage index 0..log2n-1, never narrower than one bit
    function automatic int stage_width(input int log2n);
        if (log2n <= 2) begin
            return 1;
        end
        return $clog2(log2n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tw_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tw_skid_fifo
// Description : Two-entry FIFO holding captured twiddle words together with
//               their stage index and last-of-sequence flag. Sized so the
//               one-cycle ROM read can always land while the head is stalled.
// Revision    : 1.0 - initial release
// ============================================================================
module tw_skid_fifo #(
    parameter int DATA_WIDTH  = 32,
    parameter int STAGE_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [DATA_WIDTH-1:0]  i_real,
    input  logic [DATA_WIDTH-1:0]  i_imag,
    input  logic [STAGE_WIDTH-1:0] i_stage,
    input  logic                   i_last,
    input  logic                   i_pop,
    output logic [DATA_WIDTH-1:0]  o_real,
    output logic [DATA_WIDTH-1:0]  o_imag,
    output logic [STAGE_WIDTH-1:0] o_stage,
    output logic                   o_last,
    output logic [1:0]             o_count
);

    localparam int c_ENTRY_W = 2 * DATA_WIDTH + STAGE_WIDTH + 1;

    logic [c_ENTRY_W-1:0] r_mem [2];
    logic                 r_wr_ptr;
    logic                 r_rd_ptr;
    logic [1:0]           r_count;

    logic [c_ENTRY_W-1:0] w_wr_entry;
    logic [c_ENTRY_W-1:0] w_head;
    logic                 w_pop;

    // Pack the incoming fields into one storage word
    assign w_wr_entry = {i_real, i_imag, i_stage, i_last};

    // A pop on an empty buffer is ignored so the pointers cannot skew
    assign w_pop = i_pop && (r_count != 2'd0);

    // Head entry drives the outputs directly
    assign w_head                            = r_mem[r_rd_ptr];
    assign {o_real, o_imag, o_stage, o_last} = w_head;
    assign o_count                           = r_count;

    // Storage, pointers and occupancy; push+pop together leaves the count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= w_wr_entry;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/twiddle_fetch.sv
`default_nettype none
// ============================================================================
// Module      : twiddle_fetch
// Description : Walks every stage and butterfly of an N-point radix-2 DIT FFT,
//               issues the twiddle ROM address for each, captures the returned
//               real/imag pair and streams it to the butterfly datapath over a
//               valid/ready interface with no bubbles while ready stays high.
// Revision    : 1.0 - initial release
// ============================================================================
module twiddle_fetch
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = c_DEFAULT_ADDR_WIDTH,
    parameter int LOG2N      = c_DEFAULT_LOG2N
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [DATA_WIDTH-1:0]         rom_data_real,
    input  logic [DATA_WIDTH-1:0]         rom_data_imag,
    output logic                          tw_valid,
    input  logic                          tw_ready,
    output logic [DATA_WIDTH-1:0]         tw_real,
    output logic [DATA_WIDTH-1:0]         tw_imag,
    output logic [stage_width(LOG2N)-1:0] tw_stage,
    output logic                          tw_last
);

    localparam int c_SW = stage_width(LOG2N);
    localparam int c_JW = (LOG2N > 1) ? (LOG2N - 1) : 1;

    // Final stage index and final butterfly index within a stage (N/2 - 1)
    localparam logic [c_SW-1:0] c_S_LAST = c_SW'(LOG2N - 1);
    localparam logic [c_JW-1:0] c_J_LAST = c_JW'((2 ** (LOG2N - 1)) - 1);

    // Sequencer state
    logic [c_ST_WIDTH-1:0] r_state;
    logic [c_SW-1:0]       r_s;
    logic [c_JW-1:0]       r_j;

    // Side-band that travels alongside the one-cycle ROM read
    logic                  r_inflight;
    logic [c_SW-1:0]       r_s_d;
    logic                  r_last_d;

    // Buffer interface
    logic [1:0]            w_count;
    logic                  w_pop;
    logic                  w_head_last;

    // Address generation and control
    logic [c_SW-1:0]       w_shamt;
    logic [ADDR_WIDTH-1:0] w_mask;
    logic [ADDR_WIDTH-1:0] w_k;
    logic                  w_is_last;
    logic                  w_credit;
    logic                  w_issue;
    logic                  w_drain_done;

    // Twiddle index: keep the low s bits of j, then scale up to the N/2 grid
    assign w_shamt = c_S_LAST - r_s;
    assign w_mask  = (ADDR_WIDTH'(1) << r_s) - ADDR_WIDTH'(1);
    assign w_k     = (ADDR_WIDTH'(r_j) & w_mask) << w_shamt;

    // The final butterfly of the final stage closes the issue phase
    assign w_is_last = (r_s == c_S_LAST) && (r_j == c_J_LAST);

    // Stream handshake
    assign tw_valid = (w_count != 2'd0);
    assign w_pop    = tw_valid && tw_ready;
    assign tw_last  = tw_valid && w_head_last;

    // Room exists if buffered plus in-flight words leave a free slot, or the
    // head is leaving this cycle and frees one
    assign w_credit = (({1'b0, w_count} + {2'b0, r_inflight}) < 3'd2) || w_pop;
    assign w_issue  = (r_state == c_ST_RUN) && w_credit;

    // Drain completes on the cycle the buffer goes empty with nothing in
    // flight, so done lands one cycle after the final accept
    assign w_drain_done = !r_inflight &&
                          ((w_count == 2'd0) || ((w_count == 2'd1) && w_pop));

    // Sequencer: IDLE -> RUN on start, RUN issues addresses, DRAIN empties the buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            r_s     <= '0;
            r_j     <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_state <= c_ST_RUN;
                        busy    <= 1'b1;
                        r_s     <= '0;
                        r_j     <= '0;
                    end
                end
                c_ST_RUN: begin
                    if (w_issue) begin
                        if (w_is_last) begin
                            r_state <= c_ST_DRAIN;
                        end else if (r_j == c_J_LAST) begin
                            r_j <= '0;
                            r_s <= r_s + c_SW'(1);
                        end else begin
                            r_j <= r_j + c_JW'(1);
                        end
                    end
                end
                c_ST_DRAIN: begin
                    if (w_drain_done) begin
                        r_state <= c_ST_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Address register and the side-band that accompanies the ROM read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr   <= '0;
            r_inflight <= 1'b0;
            r_s_d      <= '0;
            r_last_d   <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                rom_addr <= w_k;
                r_s_d    <= r_s;
                r_last_d <= w_is_last;
            end
        end
    end

    // Output buffer: ROM data is written the cycle after its address was issued
    tw_skid_fifo #(
        .DATA_WIDTH  (DATA_WIDTH),
        .STAGE_WIDTH (c_SW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_inflight),
        .i_real  (rom_data_real),
        .i_imag  (rom_data_imag),
        .i_stage (r_s_d),
        .i_last  (r_last_d),
        .i_pop   (w_pop),
        .o_real  (tw_real),
        .o_imag  (tw_imag),
        .o_stage (tw_stage),
        .o_last  (w_head_last),
        .o_count (w_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_twiddle_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_twiddle_fetch
// Description : Self-checking bench for twiddle_fetch (N=8 and N=16 builds)
//               against a stage/butterfly reference model and a random ROM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_twiddle_fetch;

    localparam int DW = 32;
    localparam int AW = 12;

    typedef struct {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic [1:0]    stage;
        logic          last;
    } word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // N=8 instance
    logic          start = 1'b0;
    logic          tw_ready = 1'b0;
    logic          busy, done, tw_valid, tw_last;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data_real, rom_data_imag, tw_real, tw_imag;
    logic [1:0]    tw_stage;

    // N=16 instance
    logic          start_4 = 1'b0;
    logic          ready_4 = 1'b0;
    logic          busy_4, done_4, valid_4, last_4;
    logic [AW-1:0] rom_addr_4;
    logic [DW-1:0] rom_re_4, rom_im_4, real_4, imag_4;
    logic [1:0]    stage_4;

    // ROM contents: random upper bits, address tag in the low byte
    logic [DW-1:0] rom_re [64];
    logic [DW-1:0] rom_im [64];

    // Registered-read ROM: data valid in the cycle after the address register loads
    assign rom_data_real = rom_re[rom_addr[5:0]];
    assign rom_data_imag = rom_im[rom_addr[5:0]];
    assign rom_re_4      = rom_re[rom_addr_4[5:0]];
    assign rom_im_4      = rom_im[rom_addr_4[5:0]];

    twiddle_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOG2N(3)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rom_addr(rom_addr), .rom_data_real(rom_data_real), .rom_data_imag(rom_data_imag),
        .tw_valid(tw_valid), .tw_ready(tw_ready), .tw_real(tw_real), .tw_imag(tw_imag),
        .tw_stage(tw_stage), .tw_last(tw_last)
    );

    twiddle_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOG2N(4)) dut4 (
        .clk(clk), .rst(rst), .start(start_4), .busy(busy_4), .done(done_4),
        .rom_addr(rom_addr_4), .rom_data_real(rom_re_4), .rom_data_imag(rom_im_4),
        .tw_valid(valid_4), .tw_ready(ready_4), .tw_real(real_4), .tw_imag(imag_4),
        .tw_stage(stage_4), .tw_last(last_4)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference sequence
    int exp_addr[$];
    int exp_stage[$];

    // Observations gathered by run_collect
    word_t q_words[$];
    int    acc_k[$];
    int    done_k[$];
    int    first_valid, stab_viol, max_cnt, addr_chg, cnt9, inf9;
    logic  busy0, busy_at_done;
    bit    timed_out;

    // Reference: for every stage s and butterfly j, k = (j mod 2^s) * 2^(L-1-s)
    task automatic build_expected(input int l2n);
        exp_addr.delete();
        exp_stage.delete();
        for (int s = 0; s < l2n; s++) begin
            for (int j = 0; j < (1 << (l2n - 1)); j++) begin
                exp_addr.push_back((j % (1 << s)) * (1 << (l2n - 1 - s)));
                exp_stage.push_back(s);
            end
        end
    endtask

    function automatic logic ready_for(input int mode, input int k);
        case (mode)
            1:       return ((k % 4) == 0) || ((k % 4) == 3);
            2:       return (k >= 10);
            3:       return ($urandom_range(0, 1) == 1);
            default: return 1'b1;
        endcase
    endfunction

    // Starts one sequence on the N=8 instance and records what comes out.
    // Sample index k is taken half a cycle after the k-th edge following the
    // edge that captured start. Returns at the negedge on which done is seen.
    task automatic run_collect(input int mode, input int max_k);
        logic [DW-1:0] h_re, h_im;
        logic [1:0]    h_st;
        logic          h_last;
        bit            hold;
        logic [AW-1:0] prev_addr;
        hold = 0;
        prev_addr = '0;
        h_re = '0; h_im = '0; h_st = '0; h_last = 1'b0;
        q_words.delete(); acc_k.delete(); done_k.delete();
        first_valid = -1; stab_viol = 0; max_cnt = 0; addr_chg = 0;
        cnt9 = -1; inf9 = -1; busy0 = 1'b0; busy_at_done = 1'b1; timed_out = 1;
        start = 1'b1;
        tw_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k <= max_k; k++) begin
            start = (mode == 4) && (k == 4);
            tw_ready = ready_for(mode, k);
            if (k == 0) busy0 = busy;
            if (tw_valid && first_valid < 0) first_valid = k;
            if (hold && (!tw_valid || tw_real !== h_re || tw_imag !== h_im ||
                         tw_stage !== h_st || tw_last !== h_last)) stab_viol++;
            hold = tw_valid && !tw_ready;
            h_re = tw_real; h_im = tw_imag; h_st = tw_stage; h_last = tw_last;
            if (tw_valid && tw_ready) begin
                q_words.push_back('{re: tw_real, im: tw_imag, stage: tw_stage, last: tw_last});
                acc_k.push_back(k);
            end
            if (int'(dut.u_fifo.r_count) > max_cnt) max_cnt = int'(dut.u_fifo.r_count);
            if (mode == 2 && k >= 3 && k <= 9 && rom_addr !== prev_addr) addr_chg++;
            prev_addr = rom_addr;
            if (mode == 2 && k == 9) begin
                cnt9 = int'(dut.u_fifo.r_count);
                inf9 = int'(dut.r_inflight);
            end
            if (done) begin
                done_k.push_back(k);
                busy_at_done = busy;
                timed_out = 0;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy, done, tw_valid, tw_last} !== 4'b0 || rom_addr !== '0 ||
            tw_real !== '0 || tw_imag !== '0 || tw_stage !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_n8: busy=%b done=%b valid=%b last=%b addr=%h re=%h im=%h st=%0d, want all zero",
                     busy, done, tw_valid, tw_last, rom_addr, tw_real, tw_imag, tw_stage);
        end
        n_checks++;
        if ({busy_4, done_4, valid_4, last_4} !== 4'b0 || rom_addr_4 !== '0 ||
            real_4 !== '0 || imag_4 !== '0 || stage_4 !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_n16: busy=%b done=%b valid=%b addr=%h, want all zero",
                     busy_4, done_4, valid_4, rom_addr_4);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_streaming();
        run_collect(0, 200);
        n_checks++;
        if (timed_out || busy0 !== 1'b1 || first_valid != 2) begin
            n_fail++;
            $display("FAIL stream_timing: timeout=%0b busy0=%b first_valid=%0d, want 0/1/2",
                     timed_out, busy0, first_valid);
        end
        n_checks++;
        if (q_words.size() != exp_addr.size()) begin
            n_fail++;
            $display("FAIL stream_count: got %0d words, want %0d", q_words.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < q_words.size(); i++) begin
            n_checks++;
            if (q_words[i].re !== rom_re[exp_addr[i]] || q_words[i].im !== rom_im[exp_addr[i]] ||
                q_words[i].stage !== 2'(exp_stage[i]) || q_words[i].last !== (i == exp_addr.size() - 1)) begin
                n_fail++;
                $display("FAIL stream_word[%0d]: got re=%h st=%0d last=%b, want re=%h st=%0d last=%b",
                         i, q_words[i].re, q_words[i].stage, q_words[i].last,
                         rom_re[exp_addr[i]], exp_stage[i], (i == exp_addr.size() - 1));
            end
        end
        n_checks++;
        if (acc_k.size() != 12 || acc_k[0] != 2 || acc_k[11] != 13 ||
            done_k.size() != 1 || done_k[0] != 14 || busy_at_done !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_throughput: accepts=%0d first=%0d done_at=%0d busy_at_done=%b, want 12/2/14/0",
                     acc_k.size(), (acc_k.size() > 0) ? acc_k[0] : -1,
                     (done_k.size() > 0) ? done_k[0] : -1, busy_at_done);
        end
    endtask

    // Shared by the toggle and random backpressure scenarios
    task automatic test_backpressure(input int mode);
        run_collect(mode, 400);
        n_checks++;
        if (timed_out || q_words.size() != exp_addr.size() || done_k.size() != 1 ||
            acc_k.size() == 0 || done_k[0] != acc_k[acc_k.size() - 1] + 1) begin
            n_fail++;
            $display("FAIL bp%0d_seq: timeout=%0b words=%0d done_pulses=%0d, want 0/%0d/1 done one after last accept",
                     mode, timed_out, q_words.size(), done_k.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < q_words.size(); i++) begin
            n_checks++;
            if (q_words[i].re !== rom_re[exp_addr[i]] || q_words[i].im !== rom_im[exp_addr[i]] ||
                q_words[i].stage !== 2'(exp_stage[i]) || q_words[i].last !== (i == exp_addr.size() - 1)) begin
                n_fail++;
                $display("FAIL bp%0d_word[%0d]: got re=%h im=%h, want re=%h im=%h",
                         mode, i, q_words[i].re, q_words[i].im, rom_re[exp_addr[i]], rom_im[exp_addr[i]]);
            end
        end
        n_checks++;
        if (stab_viol != 0 || max_cnt > 2) begin
            n_fail++;
            $display("FAIL bp%0d_hold: stability_violations=%0d max_count=%0d, want 0 and <=2",
                     mode, stab_viol, max_cnt);
        end
    endtask

    task automatic test_stall_start();
        test_backpressure(2);
        n_checks++;
        if (cnt9 != 2 || inf9 != 0 || addr_chg != 0 || acc_k.size() == 0 || acc_k[0] != 10) begin
            n_fail++;
            $display("FAIL stall_credit: count=%0d inflight=%0d addr_changes=%0d first_accept=%0d, want 2/0/0/10",
                     cnt9, inf9, addr_chg, (acc_k.size() > 0) ? acc_k[0] : -1);
        end
    endtask

    task automatic test_start_while_busy();
        run_collect(4, 200);
        n_checks++;
        if (timed_out || q_words.size() != 12 || done_k.size() != 1 || done_k[0] != 14) begin
            n_fail++;
            $display("FAIL restart_ignored: timeout=%0b words=%0d done_at=%0d, want 0/12/14",
                     timed_out, q_words.size(), (done_k.size() > 0) ? done_k[0] : -1);
        end
        for (int i = 0; i < exp_addr.size() && i < q_words.size(); i++) begin
            n_checks++;
            if (q_words[i].re !== rom_re[exp_addr[i]] || q_words[i].stage !== 2'(exp_stage[i])) begin
                n_fail++;
                $display("FAIL restart_word[%0d]: got re=%h st=%0d, want re=%h st=%0d",
                         i, q_words[i].re, q_words[i].stage, rom_re[exp_addr[i]], exp_stage[i]);
            end
        end
        // No trailing second sequence
        repeat (4) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || tw_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_idle: busy=%b valid=%b, want 0/0", busy, tw_valid);
        end
    endtask

    task automatic test_reset_mid_drain();
        int acc;
        bit found;
        acc = 0;
        found = 0;
        start = 1'b1;
        tw_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (acc == 11 && tw_valid) begin
                found = 1;
                break;
            end
            if (tw_valid && tw_ready) acc++;
            @(negedge clk);
        end
        n_checks++;
        if (!found || tw_last !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_setup: found=%0b last=%b busy=%b, want 1/1/1", found, tw_last, busy);
        end
        tw_ready = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if (tw_valid !== 1'b0 || tw_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rom_addr !== '0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b last=%b busy=%b done=%b addr=%h, want all zero",
                     tw_valid, tw_last, busy, done, rom_addr);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || tw_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_quiet[%0d]: done=%b valid=%b busy=%b, want 0/0/0",
                         k, done, tw_valid, busy);
            end
        end
        test_backpressure(0);
    endtask

    task automatic test_back_to_back();
        run_collect(0, 200);
        n_checks++;
        if (timed_out || done_k.size() != 1) begin
            n_fail++;
            $display("FAIL b2b_first: timeout=%0b done_pulses=%0d, want 0/1", timed_out, done_k.size());
        end
        // Next start is driven during the done cycle itself
        run_collect(0, 200);
        n_checks++;
        if (timed_out || busy0 !== 1'b1 || first_valid != 2 || q_words.size() != 12 ||
            done_k.size() != 1 || done_k[0] != 14) begin
            n_fail++;
            $display("FAIL b2b_second: timeout=%0b busy0=%b first_valid=%0d words=%0d done_at=%0d, want 0/1/2/12/14",
                     timed_out, busy0, first_valid, q_words.size(), (done_k.size() > 0) ? done_k[0] : -1);
        end
        for (int i = 0; i < exp_addr.size() && i < q_words.size(); i++) begin
            n_checks++;
            if (q_words[i].im !== rom_im[exp_addr[i]] || q_words[i].last !== (i == 11)) begin
                n_fail++;
                $display("FAIL b2b_word[%0d]: got im=%h last=%b, want im=%h last=%b",
                         i, q_words[i].im, q_words[i].last, rom_im[exp_addr[i]], (i == 11));
            end
        end
    endtask

    task automatic test_log2n4();
        word_t q4[$];
        bit    got_done;
        got_done = 0;
        build_expected(4);
        start_4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_4 = 1'b0;
        for (int k = 0; k < 400; k++) begin
            ready_4 = ($urandom_range(0, 3) != 0);
            if (valid_4 && ready_4)
                q4.push_back('{re: real_4, im: imag_4, stage: stage_4, last: last_4});
            if (done_4) begin
                got_done = 1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (!got_done || q4.size() != 32) begin
            n_fail++;
            $display("FAIL n16_count: done_seen=%0b words=%0d, want 1/32", got_done, q4.size());
        end
        for (int i = 0; i < exp_addr.size() && i < q4.size(); i++) begin
            n_checks++;
            if (q4[i].re !== rom_re[exp_addr[i]] || q4[i].im !== rom_im[exp_addr[i]] ||
                q4[i].stage !== 2'(exp_stage[i]) || q4[i].last !== (i == 31)) begin
                n_fail++;
                $display("FAIL n16_word[%0d]: got re=%h st=%0d last=%b, want addr %0d re=%h st=%0d",
                         i, q4[i].re, q4[i].stage, q4[i].last, exp_addr[i], rom_re[exp_addr[i]], exp_stage[i]);
            end
        end
        ready_4 = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            rom_re[i] = ($urandom() & 32'hFFFF_FF00) | 32'(i);
            rom_im[i] = ($urandom() & 32'hFFFF_FF00) | 32'(i) | 32'h80;
        end
        build_expected(3);
        test_reset();
        test_streaming();
        test_backpressure(1);
        test_stall_start();
        test_start_while_busy();
        test_reset_mid_drain();
        test_backpressure(3);
        test_back_to_back();
        test_log2n4();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/twiddle_fetch.md
Name: twiddle_fetch

Overview:
- Reader/sequencer for the twiddle-factor ROM pair (real and imaginary). The ROMs have a 1-cycle registered read.
- For an N-point radix-2 DIT FFT, the block walks every stage and butterfly and issues the matching twiddle ROM address.
- It captures the returned real/imag words and hands them to the butterfly datapath over a valid/ready stream.
- A 2-entry output buffer absorbs the ROM latency under backpressure, so there are no bubbles while ready is held high.

Parameters:
- DATA_WIDTH, 32, width of each twiddle word (IEEE-754 single).
- ADDR_WIDTH, 12, ROM address width.
- LOG2N, 3, log2 of FFT size (N=8). Legal range 1..ADDR_WIDTH+1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle pulse that begins a full twiddle sequence. Ignored while busy.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  single-cycle pulse after the last twiddle has been accepted downstream.
- rom_addr  out  ADDR_WIDTH  address to both ROMs, registered.
- rom_data_real  in  DATA_WIDTH  real ROM output, valid 1 cycle after rom_addr is issued.
- rom_data_imag  in  DATA_WIDTH  imaginary ROM output, same timing.
- tw_valid  out  1  buffer head valid.
- tw_ready  in  1  downstream accept.
- tw_real  out  DATA_WIDTH  head real word.
- tw_imag  out  DATA_WIDTH  head imaginary word.
- tw_stage  out  max(1,clog2(LOG2N))  stage index of the head word.
- tw_last  out  1  head is the final twiddle of the final stage.

Behaviour:
- Reset (async, active-high):
  - FSM goes to IDLE.
  - busy, done, tw_valid, tw_last = 0.
  - rom_addr, tw_real, tw_imag, tw_stage = 0.
  - Buffer count and in-flight flag are cleared.
- Reset mid-sequence: everything is discarded and the FSM returns to IDLE. No done pulse.
- FSM states:
  - IDLE: start -> RUN, with s=0, j=0. busy is high from the next cycle.
  - RUN: issues one address per cycle when credit allows. Issuing (s=LOG2N-1, j=N/2-1) -> DRAIN.
  - DRAIN: when buffer count=0 and in-flight=0 -> done=1 for one cycle, busy=0, go to IDLE.
- Address rule:
  - k = (j & (2^s - 1)) << (LOG2N-1-s).
  - rom_addr = k, zero-extended to ADDR_WIDTH.
  - j counts 0..N/2-1, then wraps to 0 and s increments.
- Issue credit:
  - issue = RUN & ((count + inflight < 2) | (tw_valid & tw_ready)).
  - At most 1 address per cycle.
  - s, last flag and an in-flight bit travel one cycle alongside the ROM read.
- Capture:
  - The cycle after an issue, {rom_data_real, rom_data_imag, s, last} is written into the 2-entry FIFO.
  - A simultaneous push and pop keeps count unchanged; order is preserved.
  - count never exceeds 2. Overflow is a design error; the bench asserts on it.
- Output:
  - tw_valid = (count > 0).
  - tw_* fields come from the head entry.
  - Once tw_valid is high, tw_* must stay stable until tw_ready.
- Latency:
  - First tw_valid appears 2 cycles after start: 1 cycle to issue, 1 cycle ROM read.
  - With tw_ready tied high, throughput is 1 twiddle per cycle.
  - Total (N/2)*LOG2N words per sequence; done follows the last accept by 1 cycle.
- start while busy: ignored, no effect on counters.
- start on the same cycle as the done pulse: accepted, new sequence begins next cycle.

Decomposition:
- Shared package fft_pkg:
  - DATA_WIDTH, ADDR_WIDTH, LOG2N defaults.
  - stage-index width function.
  - FSM state encoding {IDLE, RUN, DRAIN}.
- One natural sub-module: tw_skid_fifo, the 2-entry, DATA_WIDTH*2+stage+1-bit FIFO with push/pop/count.
- Address generation and the FSM stay in the top level.

Test Plan:
1. N=8, tw_ready=1, ROM model returns addr-tagged words -> 12 words, in this order:
   - stage 0: addresses 0,0,0,0
   - stage 1: addresses 0,2,0,2
   - stage 2: addresses 0,1,2,3
   - tw_valid first seen 2 cycles after start; tw_last only on the 12th word; done 1 cycle after the 12th accept.
2. tw_ready toggles 1,0,0,1 repeatedly -> the same 12-word sequence with no drops or duplicates, data stable while stalled, count ≤ 2 asserted throughout.
3. tw_ready=0 for 10 cycles after start -> exactly 2 addresses issued, then rom_addr frozen. On release, all 12 words are delivered in order.
4. start pulsed again mid-RUN (cycle 5) -> ignored. Exactly 12 words and a single done pulse.
5. rst asserted mid-DRAIN with 1 word buffered -> tw_valid=0 immediately (async), no done pulse. A subsequent start yields a full, correct 12-word sequence.
6. LOG2N=4 -> 32 words. Stage 3 addresses are 0..7; stage 2 addresses are 0,2,4,6 repeated twice.
